// File: rtl/mont_sequencer.sv
// mont_sequencer: control FSM that runs one Montgomery multiplication on the
// carry-save mpadder datapath.
//
// Sequence per operation:
//   IDLE -> ITER (ITERATIONS radix-4 carry-save strobes, one A digit each)
//        -> CPA  (carry-propagate pass, slice phases 0..5)
//        -> SUB  (conditional-subtract passes, phases 0..5, repeated until the
//                 adder reports subtract_finished or MAX_SUB passes elapse)
//        -> DONE (one-cycle done pulse) -> IDLE
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               single-cycle request, accepted only in IDLE
//   a_in[511:0]         operand A, captured on an accepted start
//   subtract_finished   adder flag, looked at only during SUB phase 5
//   busy                high from the cycle after start until the done cycle
//   done                one-cycle completion pulse
//   error               sticky abort flag (MAX_SUB exceeded), cleared on start
//   a_digit[1:0]        current A digit, valid while c_doubleshift=1
//   c_doubleshift       carry-save register update strobe
//   subtract            adder subtract-mode select
//   showFluffyPonies    slice/phase select (PHASE_IDLE freezes the adder)
//
// Every output comes straight from a flop; the next value of each output is
// computed together with the next state, so no input reaches an output
// combinationally.
module mont_sequencer #(
  parameter int         ITERATIONS = 256,
  parameter int         MAX_SUB    = 4,
  parameter logic [3:0] PHASE_IDLE = 4'd8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] a_in,
  input  logic         subtract_finished,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [1:0]   a_digit,
  output logic         c_doubleshift,
  output logic         subtract,
  output logic [3:0]   showFluffyPonies
);

  // One extra bit of headroom so the terminal compare never sees a wrap.
  localparam int ITER_W = $clog2(ITERATIONS + 1);
  localparam int SUB_W  = $clog2(MAX_SUB + 1);
  localparam logic [3:0] PHASE_LAST = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ITER = 3'd1,
    S_CPA  = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [511:0]        a_shift_q, a_shift_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [SUB_W-1:0]    sub_cnt_q, sub_cnt_d;
  logic [SUB_W-1:0]    sub_cnt_inc;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          a_digit_q, a_digit_d;
  logic                c_doubleshift_q, c_doubleshift_d;
  logic                subtract_q, subtract_d;
  logic [3:0]          phase_q, phase_d;

  assign sub_cnt_inc = sub_cnt_q + SUB_W'(1);

  always_comb begin
    state_d         = state_q;
    a_shift_d       = a_shift_q;
    iter_cnt_d      = iter_cnt_q;
    sub_cnt_d       = sub_cnt_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    error_d         = error_q;
    a_digit_d       = a_digit_q;
    c_doubleshift_d = c_doubleshift_q;
    subtract_d      = subtract_q;
    phase_d         = phase_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d         = S_ITER;
          // The first digit goes out with the first strobe; the shifter
          // already holds the remaining digits.
          a_digit_d       = a_in[1:0];
          a_shift_d       = {2'b00, a_in[511:2]};
          iter_cnt_d      = '0;
          error_d         = 1'b0;
          busy_d          = 1'b1;
          c_doubleshift_d = 1'b1;
        end
      end

      S_ITER: begin
        // iter_cnt_q counts strobes already presented before this cycle.
        if (iter_cnt_q == ITER_W'(ITERATIONS - 1)) begin
          state_d         = S_CPA;
          c_doubleshift_d = 1'b0;
          a_digit_d       = 2'b00;
          phase_d         = 4'd0;
        end else begin
          iter_cnt_d = iter_cnt_q + ITER_W'(1);
          a_digit_d  = a_shift_q[1:0];
          a_shift_d  = {2'b00, a_shift_q[511:2]};
        end
      end

      S_CPA: begin
        if (phase_q == PHASE_LAST) begin
          state_d    = S_SUB;
          phase_d    = 4'd0;
          subtract_d = 1'b1;
          sub_cnt_d  = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end

      S_SUB: begin
        if (phase_q == PHASE_LAST) begin
          if (subtract_finished) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            subtract_d = 1'b0;
            phase_d    = PHASE_IDLE;
          end else if (sub_cnt_inc == SUB_W'(MAX_SUB)) begin
            // Result never went non-negative: give up and flag it.
            state_d    = S_DONE;
            done_d     = 1'b1;
            error_d    = 1'b1;
            subtract_d = 1'b0;
            phase_d    = PHASE_IDLE;
          end else begin
            sub_cnt_d = sub_cnt_inc;
            phase_d   = 4'd0;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      iter_cnt_q      <= '0;
      sub_cnt_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      a_digit_q       <= 2'b00;
      c_doubleshift_q <= 1'b0;
      subtract_q      <= 1'b0;
      phase_q         <= PHASE_IDLE;
    end else begin
      state_q         <= state_d;
      iter_cnt_q      <= iter_cnt_d;
      sub_cnt_q       <= sub_cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      a_digit_q       <= a_digit_d;
      c_doubleshift_q <= c_doubleshift_d;
      subtract_q      <= subtract_d;
      phase_q         <= phase_d;
    end
  end

  // Operand shifter is pure data: it is always reloaded on start.
  always_ff @(posedge clk) begin
    a_shift_q <= a_shift_d;
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign a_digit          = a_digit_q;
  assign c_doubleshift    = c_doubleshift_q;
  assign subtract         = subtract_q;
  assign showFluffyPonies = phase_q;

endmodule

// File: tb/tb_mont_sequencer.sv
// Testbench for mont_sequencer: randomized operations, a queue-based
// scoreboard filled when each operation is issued, and an independent monitor
// that pops and compares whenever the DUT strobes a digit, shows a slice
// phase, or pulses done. A small responder plays the adder's
// subtract_finished flag (asserted on a chosen subtract pass, random noise
// elsewhere).
module tb_mont_sequencer;

  localparam int         ITERATIONS = 256;
  localparam int         MAX_SUB    = 4;
  localparam logic [3:0] PHASE_IDLE = 4'd8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [511:0] a_in;
  logic         subtract_finished;
  logic         busy;
  logic         done;
  logic         error;
  logic [1:0]   a_digit;
  logic         c_doubleshift;
  logic         subtract;
  logic [3:0]   showFluffyPonies;

  mont_sequencer #(
    .ITERATIONS(ITERATIONS),
    .MAX_SUB   (MAX_SUB),
    .PHASE_IDLE(PHASE_IDLE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .a_in             (a_in),
    .subtract_finished(subtract_finished),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .a_digit          (a_digit),
    .c_doubleshift    (c_doubleshift),
    .subtract         (subtract),
    .showFluffyPonies (showFluffyPonies)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [1:0] digit_q[$];
  logic [4:0] phase_q[$];
  int         done_cyc_q[$];
  logic       err_q[$];

  bit done_seen;
  int sf_target;
  int sub5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Adder stand-in: finish on the sf_target-th subtract pass (0 = never).
  always @(negedge clk) begin
    if (!busy) sub5 = 0;
    if (subtract && showFluffyPonies == 4'd5) begin
      sub5++;
      subtract_finished = (sub5 == sf_target);
    end else begin
      subtract_finished = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk("strobe_subtract_exclusive", {63'd0, c_doubleshift & subtract}, 64'd0);
      if (c_doubleshift) begin
        if (digit_q.size() == 0) chk("unexpected_strobe", {63'd0, c_doubleshift}, 64'd0);
        else chk("a_digit", {62'd0, a_digit}, {62'd0, digit_q.pop_front()});
      end
      if (showFluffyPonies != PHASE_IDLE) begin
        if (phase_q.size() == 0) chk("unexpected_phase", {60'd0, showFluffyPonies}, {60'd0, PHASE_IDLE});
        else chk("sub_phase", {59'd0, subtract, showFluffyPonies}, {59'd0, phase_q.pop_front()});
      end
      if (done) begin
        if (done_cyc_q.size() == 0) chk("unexpected_done", {63'd0, done}, 64'd0);
        else begin
          chk("done_cycle", 64'(cyc), 64'(done_cyc_q.pop_front()));
          chk("done_error", {63'd0, error}, {63'd0, err_q.pop_front()});
          chk("done_phase_idle", {60'd0, showFluffyPonies}, {60'd0, PHASE_IDLE});
          chk("sequence_drained", 64'(digit_q.size() + phase_q.size()), 64'd0);
        end
        done_seen = 1'b1;
      end
    end
  end

  // Reference model: digit i of A is floor(A / 4^i) mod 4; the phase list is
  // one CPA pass then the expected number of subtract passes.
  task automatic begin_op(input logic [511:0] a, input int target);
    int           passes;
    logic [511:0] t;
    passes = (target == 0) ? MAX_SUB : target;
    @(negedge clk); #1;
    for (int i = 0; i < ITERATIONS; i++) begin
      t = a >> (2 * i);
      digit_q.push_back(t[1:0]);
    end
    for (int k = 0; k < 6; k++) phase_q.push_back({1'b0, 4'(k)});
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < 6; k++) phase_q.push_back({1'b1, 4'(k)});
    done_cyc_q.push_back(cyc + 1 + ITERATIONS + 6 + 6 * passes);
    err_q.push_back(target == 0);
    sf_target = target;
    done_seen = 1'b0;
    a_in      = a;
    start     = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("error_cleared_on_start", {63'd0, error}, 64'd0);
  endtask

  task automatic finish_op(input bit noise, input bit done_start);
    for (int k = 0; k < 400 && !done_seen; k++) begin
      @(negedge clk); #1;
      if (noise && !done_seen) begin
        start = 1'($urandom_range(0, 1));
        a_in  = rand512();
      end
    end
    chk("done_timeout", {63'd0, done_seen}, 64'd1);
    start = done_start;
    a_in  = rand512();
    @(negedge clk); #1;
    start = 1'b0;
    chk("idle_after_done_busy", {63'd0, busy}, 64'd0);
    chk("idle_after_done_strobe", {63'd0, c_doubleshift}, 64'd0);
  endtask

  task automatic run_op(input logic [511:0] a, input int target, input bit noise,
                        input bit done_start);
    begin_op(a, target);
    finish_op(noise, done_start);
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_err);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
    chk({tag, "_a_digit"}, {62'd0, a_digit}, 64'd0);
    chk({tag, "_c_doubleshift"}, {63'd0, c_doubleshift}, 64'd0);
    chk({tag, "_subtract"}, {63'd0, subtract}, 64'd0);
    chk({tag, "_phase"}, {60'd0, showFluffyPonies}, 64'd8);
  endtask

  initial begin
    logic [511:0] a;
    reset     = 1'b1;
    start     = 1'b0;
    a_in      = '0;
    sf_target = 1;
    done_seen = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    #1 check_idle_outputs("reset", 1'b0);

    // Low byte 1110_0100b: digits start 0,1,2,3; single subtract pass.
    a = rand512();
    a[7:0] = 8'hE4;
    run_op(a, 1, 1'b0, 1'b0);

    // Finish on third subtract pass.
    run_op(rand512(), 3, 1'b0, 1'b0);

    // Never finishes: abort with error, start in the DONE cycle is ignored.
    run_op(rand512(), 0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    #1 check_idle_outputs("sticky", 1'b1);

    // Start noise while busy.
    run_op(rand512(), 2, 1'b1, 1'b1);
    run_op(rand512(), MAX_SUB, 1'b1, 1'b0);

    // Reset in the middle of ITER, then a clean full run.
    begin_op(rand512(), 1);
    repeat (99) @(negedge clk);
    #1 reset = 1'b1;
    digit_q.delete();
    phase_q.delete();
    done_cyc_q.delete();
    err_q.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    check_idle_outputs("mid_reset", 1'b0);
    run_op(rand512(), 1, 1'b0, 1'b0);

    for (int n = 0; n < 3; n++)
      run_op(rand512(), int'($urandom_range(0, MAX_SUB)), 1'b1, 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_sequencer.md
Name: mont_sequencer

Overview:
- Control FSM that runs one Montgomery multiplication on the carry-save mpadder datapath.
- On start it latches operand A and steps the radix-4 carry-save iterations (one c_doubleshift per cycle, one 2-bit A digit each).
- It then drives the 104-bit-slice carry-propagate pass (phase codes 1..5), followed by repeated conditional-subtract passes until the datapath flags subtract_finished.
- It sits between the top-level AXI/host FSM (start/done) and mpadder (subtract, c_doubleshift, showFluffyPonies).

Parameters:
- ITERATIONS, 256, number of radix-4 carry-save iterations (512-bit A / 2 bits per iteration).
- MAX_SUB, 4, maximum subtract passes before abort with error.
- PHASE_IDLE, 4'd8, phase code driven when no slice is active (bit 3 set freezes the adder pipeline registers).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; accepted only in IDLE
- a_in  in  512  operand A, sampled on accepted start
- subtract_finished  in  1  from adder: final subtract pass produced a non-negative result
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; trueResult is valid in that cycle
- error  out  1  sticky; MAX_SUB exceeded; cleared on the next accepted start
- a_digit  out  2  current A digit (selects the B0..B3 multiple); valid while c_doubleshift=1
- c_doubleshift  out  1  carry-save register update strobe
- subtract  out  1  adder in subtract mode
- showFluffyPonies  out  4  slice/phase select to adder

Behaviour:
- Reset values: busy=0, done=0, error=0, a_digit=0, c_doubleshift=0, subtract=0, showFluffyPonies=PHASE_IDLE; state=IDLE; counters=0.
- Reset is synchronous and overrides every other input, including mid-operation; the next cycle is IDLE with all outputs at reset values.
- All outputs are registered. No combinational path from any input to any output.
- States and transitions:
  - IDLE: start=1 -> load a_shift<=a_in, iter_cnt<=0, error<=0, go to ITER. start is ignored in every other state.
  - ITER: c_doubleshift=1, a_digit=a_shift[1:0]; each cycle a_shift>>=2 and iter_cnt++. Exactly ITERATIONS strobe cycles, back-to-back. After the last strobe go to CPA with phase=0.
  - CPA: subtract=0; showFluffyPonies steps 0,1,2,3,4,5 on consecutive cycles (6 cycles). Operands are registered at phase k and summed at phase k+1, so phase 0 only loads the pipeline. Next: SUB with phase=0, sub_cnt=0.
  - SUB: subtract=1; phases 0..5 as in CPA. Phase 0 loads c_regb from the previous result.
  - SUB, evaluated during phase 5:
    - subtract_finished=1 -> go to DONE.
    - Otherwise sub_cnt++. If sub_cnt reaches MAX_SUB -> error<=1, go to DONE.
    - Otherwise restart at phase 0.
  - DONE: done=1 for one cycle, subtract=0, phase=PHASE_IDLE, busy=0 in the following cycle; go to IDLE.
- subtract_finished is ignored outside SUB phase 5.
- Between states and in IDLE/DONE, showFluffyPonies=PHASE_IDLE and c_doubleshift=0.
- c_doubleshift and subtract are never high in the same cycle.
- Latency, start to done, with one subtract pass: 1 + ITERATIONS + 6 + 6 + 1 cycles = 270 at defaults. Each extra subtract pass adds 6.
- A start arriving in the DONE cycle is ignored. A start in the cycle after DONE is accepted.
- iter_cnt is 9 bits and must not wrap before the terminal compare. sub_cnt is ceil(log2(MAX_SUB+1)) bits.

Test Plan:
- Reset then idle 10 cycles → all outputs at reset values, showFluffyPonies=8.
- start with a_in=512'h...E4 (low byte 1110_0100b), subtract_finished tied 1 on the first SUB phase 5:
  - c_doubleshift high for exactly 256 consecutive cycles;
  - a_digit sequence begins 0,1,2,3;
  - CPA phases 0..5, then SUB phases 0..5;
  - done at cycle 270 after start;
  - error=0.
- subtract_finished asserted on the third SUB phase 5 → 3 SUB passes, done at cycle 282, error=0.
- subtract_finished never asserted with MAX_SUB=4 → 4 SUB passes, error=1, done pulse, error stays 1 until the next start.
- reset asserted at cycle 100 of ITER, then start → clean restart; full 256-strobe sequence; no residual count.
- start pulsed during busy and in the DONE cycle → ignored; glitch of subtract_finished during CPA → no effect on sequencing.
